// File: rtl/mem_addr_seq_if.sv
// Request, memory-beat and completion signals of the address sequencer.
// Build option: MEM_ADDR_SEQ_ALIGN_CHK_EN adds align_err_out.
// master = requester / memory side, slave = the sequencer itself.
interface mem_addr_seq_if #(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 16,
    parameter int IDX_W  = 4
);
    // request side
    logic              start_in;
    logic [2:0]        func_in;
    logic              multi_in;
    logic              swp_in;
    logic [ADDR_W-1:0] base_addr_in;
    logic [ADDR_W-1:0] offset_in;
    logic [LIST_W-1:0] reg_list_in;
    // memory beat handshake
    logic              mem_ready_in;
    logic              addr_valid_out;
    logic [ADDR_W-1:0] addr_out;
    logic [IDX_W-1:0]  reg_idx_out;
    logic              last_out;
    // status / completion
    logic              busy_out;
    logic              done_out;
    logic              wb_valid_out;
    logic [ADDR_W-1:0] wb_data_out;
`ifdef MEM_ADDR_SEQ_ALIGN_CHK_EN
    logic              align_err_out;

    modport master (
        output start_in, func_in, multi_in, swp_in, base_addr_in, offset_in, reg_list_in, mem_ready_in,
        input  addr_valid_out, addr_out, reg_idx_out, last_out, busy_out, done_out, wb_valid_out,
               wb_data_out, align_err_out
    );
    modport slave (
        input  start_in, func_in, multi_in, swp_in, base_addr_in, offset_in, reg_list_in, mem_ready_in,
        output addr_valid_out, addr_out, reg_idx_out, last_out, busy_out, done_out, wb_valid_out,
               wb_data_out, align_err_out
    );
`else
    modport master (
        output start_in, func_in, multi_in, swp_in, base_addr_in, offset_in, reg_list_in, mem_ready_in,
        input  addr_valid_out, addr_out, reg_idx_out, last_out, busy_out, done_out, wb_valid_out,
               wb_data_out
    );
    modport slave (
        input  start_in, func_in, multi_in, swp_in, base_addr_in, offset_in, reg_list_in, mem_ready_in,
        output addr_valid_out, addr_out, reg_idx_out, last_out, busy_out, done_out, wb_valid_out,
               wb_data_out
    );
`endif
endinterface

// File: rtl/mem_addr_seq.sv
// Multi-beat memory address sequencer: LDM/STM (IA/IB/DA/DB), LDR/STR, SWP.
// Latency: beat 0 the cycle after start, done one cycle after the last beat; holds beat while mem_ready_in=0.
// Build option: MEM_ADDR_SEQ_ALIGN_CHK_EN rejects a misaligned first address with align_err_out.
module mem_addr_seq #(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 16,
    parameter int IDX_W  = 4,
    parameter int STEP   = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_addr_seq_if.slave bus
);
    localparam int CNT_W = $clog2(LIST_W) + 1;
    localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LIST_W-1:0] list_q, list_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              swp_q, swp_d;
    logic              blk_q, blk_d;
    logic [ADDR_W-1:0] wb_q, wb_d;
    logic              wb_en_q, wb_en_d;
    logic              err_q, err_d;

    // decoded request (from the live inputs, used only on the start cycle)
    logic [CNT_W-1:0]  req_n;
    logic [CNT_W-1:0]  req_cnt;
    logic [ADDR_W-1:0] req_span;
    logic [ADDR_W-1:0] req_off;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_wb;
    logic              req_wb_en;
    logic              req_bad;
    logic              hs;

    function automatic logic [CNT_W-1:0] popcnt(input logic [LIST_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LIST_W; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // Scans downwards so the lowest set bit is the one that sticks.
    function automatic logic [IDX_W-1:0] low_idx(input logic [LIST_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = LIST_W - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    // Decode the request into beat count, first address and writeback value.
    always_comb begin
        req_n     = popcnt(bus.reg_list_in);
        req_span  = ADDR_W'(req_n) * STEP_W;
        req_off   = bus.func_in[1] ? bus.base_addr_in + bus.offset_in
                                   : bus.base_addr_in - bus.offset_in;
        req_cnt   = '0;
        req_addr  = bus.base_addr_in;
        req_wb    = bus.base_addr_in;
        req_wb_en = 1'b0;
        if (bus.swp_in) begin
            req_cnt = CNT_W'(2);
        end else if (bus.multi_in) begin
            req_cnt = req_n;
            // Beats always ascend, so the start is the lowest address of the block.
            case (bus.func_in[2:1])
                2'b01:   req_addr = bus.base_addr_in;                     // IA
                2'b11:   req_addr = bus.base_addr_in + STEP_W;            // IB
                2'b00:   req_addr = bus.base_addr_in - req_span + STEP_W; // DA
                default: req_addr = bus.base_addr_in - req_span;          // DB
            endcase
            req_wb    = bus.func_in[1] ? bus.base_addr_in + req_span
                                       : bus.base_addr_in - req_span;
            req_wb_en = bus.func_in[0] | ~bus.func_in[2];
        end else begin
            req_cnt   = CNT_W'(1);
            req_addr  = bus.func_in[2] ? req_off : bus.base_addr_in;
            req_wb    = req_off;
            req_wb_en = bus.func_in[0] | ~bus.func_in[2];
        end
`ifdef MEM_ADDR_SEQ_ALIGN_CHK_EN
        req_bad = (req_cnt != '0) && (req_addr[1:0] != 2'b00);
`else
        req_bad = 1'b0;
`endif
    end

    // Next-state and datapath updates for the IDLE/XFER/DONE sequence.
    always_comb begin
        hs      = (state_q == S_XFER) && bus.mem_ready_in;
        state_d = state_q;
        addr_d  = addr_q;
        list_d  = list_q;
        cnt_d   = cnt_q;
        swp_d   = swp_q;
        blk_d   = blk_q;
        wb_d    = wb_q;
        wb_en_d = wb_en_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    addr_d  = req_addr;
                    list_d  = bus.reg_list_in;
                    cnt_d   = req_cnt;
                    swp_d   = bus.swp_in;
                    blk_d   = bus.multi_in & ~bus.swp_in;
                    wb_d    = req_wb;
                    wb_en_d = req_wb_en & ~req_bad;
                    err_d   = req_bad;
                    state_d = ((req_cnt == '0) || req_bad) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (hs) begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    list_d = list_q & (list_q - LIST_W'(1)); // retire lowest register
                    addr_d = swp_q ? addr_q : addr_q + STEP_W;
                    if (cnt_q == CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any transfer without a completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            list_q  <= '0;
            cnt_q   <= '0;
            swp_q   <= 1'b0;
            blk_q   <= 1'b0;
            wb_q    <= '0;
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            list_q  <= list_d;
            cnt_q   <= cnt_d;
            swp_q   <= swp_d;
            blk_q   <= blk_d;
            wb_q    <= wb_d;
            wb_en_q <= wb_en_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from registered state, so they hold through stalls.
    always_comb begin
        bus.busy_out       = (state_q != S_IDLE);
        bus.addr_valid_out = (state_q == S_XFER);
        bus.addr_out       = addr_q;
        bus.reg_idx_out    = blk_q ? low_idx(list_q) : '0;
        bus.last_out       = (state_q == S_XFER) && (cnt_q == CNT_W'(1));
        bus.done_out       = (state_q == S_DONE);
        bus.wb_valid_out   = (state_q == S_DONE) && wb_en_q;
        bus.wb_data_out    = wb_q;
`ifdef MEM_ADDR_SEQ_ALIGN_CHK_EN
        bus.align_err_out  = (state_q == S_DONE) && err_q;
`endif
    end

endmodule

// File: tb/tb_mem_addr_seq.sv
// Randomised + directed bench for mem_addr_seq against a transfer-level model.
// Model lists the expected beats of each request and the completion result.
// Memory ready is randomised to exercise stalls; start_in is pulsed while busy.
module tb_mem_addr_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_addr_seq_if bus ();
    mem_addr_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.func_in      = 3'($urandom);
        bus.multi_in     = 1'($urandom);
        bus.swp_in       = 1'($urandom);
        bus.base_addr_in = $urandom;
        bus.offset_in    = $urandom;
        bus.reg_list_in  = 16'($urandom);
    endtask

    // Caller is positioned at a falling edge with the sequencer idle.
    task automatic run_req(input logic [2:0] func, input logic multi, input logic swp,
                           input logic [31:0] base, input logic [31:0] off,
                           input logic [15:0] list, input int ready_pct, input logic noise);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_idx[$];
        logic [31:0] exp_wb, lowest, first;
        logic        exp_wbv, exp_err;
        logic        rdy;
        int          n, rank, k, guard;
        bit          p, u, w;
        p = func[2]; u = func[1]; w = func[0];
        exp_err = 1'b0;
        exp_wb  = base;
        exp_wbv = 1'b0;
        if (swp) begin
            exp_addr.push_back(base); exp_idx.push_back(0);
            exp_addr.push_back(base); exp_idx.push_back(0);
        end else if (multi) begin
            n = $countones(list);
            // The block occupies n words; ascending issue starts from its lowest word.
            if (u) lowest = p ? base + 4 : base;
            else   lowest = p ? base - 4 * n : base - 4 * n + 4;
            rank = 0;
            for (int i = 0; i < 16; i++) begin
                if (list[i]) begin
                    exp_addr.push_back(lowest + 4 * rank);
                    exp_idx.push_back(i);
                    rank++;
                end
            end
            exp_wb  = u ? base + 4 * n : base - 4 * n;
            exp_wbv = w | !p;
        end else begin
            exp_wb  = u ? base + off : base - off;
            exp_addr.push_back(p ? exp_wb : base);
            exp_idx.push_back(0);
            exp_wbv = w | !p;
        end
`ifdef MEM_ADDR_SEQ_ALIGN_CHK_EN
        if (exp_addr.size() > 0) begin
            first = exp_addr[0];
            if (first[1:0] != 2'b00) begin
                exp_err = 1'b1;
                exp_wbv = 1'b0;
                exp_addr.delete();
                exp_idx.delete();
            end
        end
`else
        first = 32'h0;
`endif
        bus.func_in = func; bus.multi_in = multi; bus.swp_in = swp;
        bus.base_addr_in = base; bus.offset_in = off; bus.reg_list_in = list;
        bus.mem_ready_in = 1'b0;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        k = 0; guard = 0;
        while (k < exp_addr.size() && guard < 400) begin
            chk("beat_valid", {31'b0, bus.addr_valid_out}, 32'd1);
            chk("beat_busy", {31'b0, bus.busy_out}, 32'd1);
            chk("beat_addr", bus.addr_out, exp_addr[k]);
            chk("beat_idx", {28'b0, bus.reg_idx_out}, exp_idx[k]);
            chk("beat_last", {31'b0, bus.last_out}, (k == exp_addr.size() - 1) ? 32'd1 : 32'd0);
            chk("beat_nodone", {31'b0, bus.done_out}, 32'd0);
            rdy = ($urandom_range(0, 99) < ready_pct);
            bus.mem_ready_in = rdy;
            if (noise) begin
                scramble_inputs();
                bus.start_in = 1'($urandom);
            end
            @(negedge clk);
            if (rdy) k++;
            guard++;
        end
        if (guard >= 400) chk("beat_timeout", 32'd0, 32'd1);
        bus.start_in = 1'b0;
        bus.mem_ready_in = 1'b0;
        chk("done_pulse", {31'b0, bus.done_out}, 32'd1);
        chk("done_busy", {31'b0, bus.busy_out}, 32'd1);
        chk("done_novalid", {31'b0, bus.addr_valid_out}, 32'd0);
        chk("done_wbv", {31'b0, bus.wb_valid_out}, {31'b0, exp_wbv});
        if (!swp && !exp_err) chk("done_wbdata", bus.wb_data_out, exp_wb);
`ifdef MEM_ADDR_SEQ_ALIGN_CHK_EN
        chk("done_alignerr", {31'b0, bus.align_err_out}, {31'b0, exp_err});
`endif
        @(negedge clk);
        chk("idle_busy", {31'b0, bus.busy_out}, 32'd0);
        chk("idle_done", {31'b0, bus.done_out}, 32'd0);
        chk("idle_wbv", {31'b0, bus.wb_valid_out}, 32'd0);
        if (!swp && !exp_err) chk("idle_wbhold", bus.wb_data_out, exp_wb);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, bus.busy_out}, 32'd0);
        chk({tag, "_valid"}, {31'b0, bus.addr_valid_out}, 32'd0);
        chk({tag, "_addr"}, bus.addr_out, 32'd0);
        chk({tag, "_idx"}, {28'b0, bus.reg_idx_out}, 32'd0);
        chk({tag, "_last"}, {31'b0, bus.last_out}, 32'd0);
        chk({tag, "_done"}, {31'b0, bus.done_out}, 32'd0);
        chk({tag, "_wbv"}, {31'b0, bus.wb_valid_out}, 32'd0);
        chk({tag, "_wbdata"}, bus.wb_data_out, 32'd0);
`ifdef MEM_ADDR_SEQ_ALIGN_CHK_EN
        chk({tag, "_alignerr"}, {31'b0, bus.align_err_out}, 32'd0);
`endif
    endtask

    initial begin
        bus.start_in = 1'b0; bus.mem_ready_in = 1'b0;
        bus.func_in = 3'b0; bus.multi_in = 1'b0; bus.swp_in = 1'b0;
        bus.base_addr_in = 32'h0; bus.offset_in = 32'h0; bus.reg_list_in = 16'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_req(3'b011, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 16'h00F1, 100, 1'b0); // IA
        run_req(3'b101, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 16'h000B, 50, 1'b0);  // DB, stalls
        run_req(3'b111, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 16'h8001, 60, 1'b1);  // IB
        run_req(3'b001, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 16'h0810, 60, 1'b1);  // DA
        run_req(3'b100, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 16'h0006, 100, 1'b0); // P=1 W=0 block
        run_req(3'b000, 1'b0, 1'b0, 32'h0000_0100, 32'h20, 16'h0, 100, 1'b0);   // post-sub
        run_req(3'b110, 1'b0, 1'b0, 32'h0000_0100, 32'h20, 16'h0, 100, 1'b0);   // pre-add, no wb
        run_req(3'b011, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 16'h00FF, 70, 1'b1);  // swap
        run_req(3'b011, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 16'h0000, 100, 1'b0); // empty list
        run_req(3'b011, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 16'h0003, 100, 1'b0); // wrap
        run_req(3'b011, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 16'hFFFF, 100, 1'b0); // full list
`ifdef MEM_ADDR_SEQ_ALIGN_CHK_EN
        run_req(3'b011, 1'b1, 1'b0, 32'h0000_1002, 32'h0, 16'h0003, 100, 1'b0); // misaligned
`endif

        // randomised requests, back-to-back
        for (int t = 0; t < 300; t++) begin
            logic [15:0] lst;
            lst = 16'($urandom);
            if ($urandom_range(0, 7) == 0) lst = 16'h0;
            else if ($urandom_range(0, 3) == 0) lst = lst & 16'($urandom);
            run_req(3'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                    $urandom, $urandom, lst, $urandom_range(30, 100), 1'($urandom));
        end

        // reset in the middle of a block transfer
        bus.func_in = 3'b011; bus.multi_in = 1'b1; bus.swp_in = 1'b0;
        bus.base_addr_in = 32'h0000_5000; bus.reg_list_in = 16'hFFFF;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        bus.mem_ready_in = 1'b1;
        @(negedge clk);
        chk("pre_rst_addr", bus.addr_out, 32'h0000_5004);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_done", {31'b0, bus.done_out}, 32'd0);
            chk("post_rst_busy", {31'b0, bus.busy_out}, 32'd0);
        end
        bus.mem_ready_in = 1'b0;
        run_req(3'b011, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 16'h0005, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
